// File: rtl/palette_pkg.sv
// Shared definitions for the palette engine: default RGB444 palette,
// fade FSM state encoding and the full-brightness fade level.
package palette_pkg;

    localparam int unsigned LEVEL_W = 5;
    localparam logic [LEVEL_W-1:0] FADE_FULL = 5'd16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_IN  = 2'd1,
        FADE_OUT = 2'd2
    } fade_state_t;

    // {R,G,B} nibbles, entry 0 first
    localparam logic [11:0] DEFAULT_PALETTE [16] = '{
        12'h000, 12'h800, 12'hD65, 12'h29E,
        12'h0A0, 12'h616, 12'hA50, 12'hFFF,
        12'h555, 12'hF55, 12'h5F5, 12'hFF5,
        12'h55F, 12'hF5F, 12'h5FF, 12'hAAA
    };

    function automatic logic [11:0] default_rgb444(input int unsigned idx);
        return (idx < 16) ? DEFAULT_PALETTE[idx[3:0]] : 12'h000;
    endfunction

endpackage

// File: rtl/palette_engine_if.sv
// Lookup and entry-write bus of the palette engine.
interface palette_engine_if #(
    parameter int IDX_W  = 4,
    parameter int CH_W   = 4,
    parameter int NBANKS = 2
);
    localparam int BANK_W = (NBANKS > 1) ? $clog2(NBANKS) : 1;

    logic              rd_valid;
    logic [IDX_W-1:0]  rd_idx;
    logic [CH_W-1:0]   red;
    logic [CH_W-1:0]   green;
    logic [CH_W-1:0]   blue;
    logic              out_valid;
    logic              wr_en;
    logic [BANK_W-1:0] wr_bank;
    logic [IDX_W-1:0]  wr_idx;
    logic [3*CH_W-1:0] wr_rgb;

    modport master (
        output rd_valid, rd_idx, wr_en, wr_bank, wr_idx, wr_rgb,
        input  red, green, blue, out_valid
    );

    modport slave (
        input  rd_valid, rd_idx, wr_en, wr_bank, wr_idx, wr_rgb,
        output red, green, blue, out_valid
    );
endinterface

// File: rtl/palette_fade.sv
// Fade FSM: steps a 0..16 brightness level once per frame_start while
// fading in or out; fade_busy is high whenever a fade is in progress.
module palette_fade
    import palette_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_start,
    input  logic               fade_start,
    input  logic               fade_dir,
    output logic [LEVEL_W-1:0] level,
    output logic               fade_busy
);

    fade_state_t        state_reg, state_next;
    logic [LEVEL_W-1:0] level_reg, level_next;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg <= IDLE;
            level_reg <= FADE_FULL;
        end else begin
            state_reg <= state_next;
            level_reg <= level_next;
        end
    end

    // Entering a fade never steps the level, even with frame_start on the same edge
    always_comb begin
        state_next = state_reg;
        level_next = level_reg;
        unique case (state_reg)
            IDLE: begin
                if (fade_start) state_next = fade_dir ? FADE_IN : FADE_OUT;
            end
            FADE_IN: begin
                if (frame_start) begin
                    if (level_reg < FADE_FULL) level_next = level_reg + 1'b1;
                    if (level_reg >= FADE_FULL - 5'd1) state_next = IDLE;
                end
            end
            FADE_OUT: begin
                if (frame_start) begin
                    if (level_reg != '0) level_next = level_reg - 1'b1;
                    if (level_reg <= 5'd1) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign level     = level_reg;
    assign fade_busy = (state_reg != IDLE);

endmodule

// File: rtl/palette_engine.sv
// Banked colour palette with a 2-stage lookup pipeline and frame-synchronous
// bank switching; define PALETTE_ENGINE_FADE_EN to add fade in/out scaling.
module palette_engine
    import palette_pkg::*;
#(
    parameter int IDX_W  = 4,
    parameter int CH_W   = 4,
    parameter int NBANKS = 2,
    localparam int BANK_W = (NBANKS > 1) ? $clog2(NBANKS) : 1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              frame_start,
    palette_engine_if.slave   bus,
    input  logic [BANK_W-1:0] bank_req,
    output logic [BANK_W-1:0] active_bank,
    input  logic              fade_start,
    input  logic              fade_dir,
    output logic              fade_busy
);

    localparam int unsigned DEPTH   = 2 ** IDX_W;
    localparam int unsigned ENTRIES = NBANKS * DEPTH;
    localparam int          AW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int          RGB_W   = 3 * CH_W;

    function automatic logic [RGB_W-1:0] reset_entry(input int unsigned flat);
        logic [11:0] d;
        d = (flat < DEPTH) ? default_rgb444(flat) : 12'h000;
        return {CH_W'(d[11:8]), CH_W'(d[7:4]), CH_W'(d[3:0])};
    endfunction

    logic [RGB_W-1:0]  mem [ENTRIES];
    logic [AW-1:0]     wr_addr, rd_addr;
    logic              wr_ok;
    logic [BANK_W-1:0] pending_reg, pending_next, active_reg;
    logic              s1_valid_reg;
    logic [RGB_W-1:0]  s1_rgb_reg;
    logic [CH_W-1:0]   s1_ch [3];
    logic [CH_W-1:0]   scaled_ch [3];
    logic [CH_W-1:0]   red_reg, green_reg, blue_reg;
    logic              out_valid_reg;

    assign wr_addr = AW'(int'(bus.wr_bank) * DEPTH + int'(bus.wr_idx));
    assign wr_ok   = bus.wr_en && (int'(bus.wr_bank) < NBANKS);
    assign rd_addr = AW'(int'(active_reg) * DEPTH + int'(bus.rd_idx));

    // Storage is reset to the default palette, so it lives in flops
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) mem[AW'(i)] <= reset_entry(i);
        end else if (wr_ok) begin
            mem[wr_addr] <= bus.wr_rgb;
        end
    end

    // Out-of-range requests keep the previous pending bank
    assign pending_next = (int'(bank_req) < NBANKS) ? bank_req : pending_reg;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pending_reg <= '0;
            active_reg  <= '0;
        end else begin
            pending_reg <= pending_next;
            if (frame_start) active_reg <= pending_next;
        end
    end

    assign active_bank = active_reg;

    // Stage 1 reads the array on the request edge: a same-edge write is not seen
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid_reg <= 1'b0;
            s1_rgb_reg   <= '0;
        end else begin
            s1_valid_reg <= bus.rd_valid;
            if (bus.rd_valid) s1_rgb_reg <= mem[rd_addr];
        end
    end

`ifdef PALETTE_ENGINE_FADE_EN
    logic [LEVEL_W-1:0] level;

    palette_fade u_fade (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_start (frame_start),
        .fade_start  (fade_start),
        .fade_dir    (fade_dir),
        .level       (level),
        .fade_busy   (fade_busy)
    );
`else
    logic unused_fade;
    assign unused_fade = fade_start ^ fade_dir;
    assign fade_busy   = 1'b0;
`endif

    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
        assign s1_ch[gi] = s1_rgb_reg[(2-gi)*CH_W +: CH_W];
`ifdef PALETTE_ENGINE_FADE_EN
        logic [CH_W+LEVEL_W-1:0] prod;
        logic [CH_W:0]           shifted;
        assign prod          = (CH_W+LEVEL_W)'(s1_ch[gi]) * (CH_W+LEVEL_W)'(level);
        assign shifted       = (CH_W+1)'(prod >> 4);
        assign scaled_ch[gi] = shifted[CH_W] ? '1 : shifted[CH_W-1:0];
`else
        assign scaled_ch[gi] = s1_ch[gi];
`endif
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            out_valid_reg <= 1'b0;
            red_reg       <= '0;
            green_reg     <= '0;
            blue_reg      <= '0;
        end else begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                red_reg   <= scaled_ch[0];
                green_reg <= scaled_ch[1];
                blue_reg  <= scaled_ch[2];
            end
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.red       = red_reg;
    assign bus.green     = green_reg;
    assign bus.blue      = blue_reg;

endmodule

// File: doc/palette_engine.md
PALETTE_ENGINE -- requirements
Module: palette_engine

Interface
REQ-001 SHALL have parameter IDX_W, default 4, colour index width; palette depth is 2**IDX_W.
REQ-002 SHALL have parameter CH_W, default 4, bits per colour channel.
REQ-003 SHALL have parameter NBANKS, default 2, number of palette banks, minimum 1.
REQ-004 SHALL have port Clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port Reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port frame_start  input  1  one-cycle pulse at start of vertical blank.
REQ-007 SHALL have port rd_valid  input  1  lookup request qualifier.
REQ-008 SHALL have port rd_idx  input  IDX_W  colour index to look up.
REQ-009 SHALL have ports red, green, blue  output  CH_W each  looked-up colour.
REQ-010 SHALL have port out_valid  output  1  red/green/blue valid.
REQ-011 SHALL have ports wr_en  input  1; wr_bank  input  $clog2(NBANKS) (min 1); wr_idx  input  IDX_W; wr_rgb  input  3*CH_W {R,G,B} -- entry write.
REQ-012 SHALL have ports bank_req  input  $clog2(NBANKS) (min 1) requested bank; active_bank  output  same width.
REQ-013 SHALL have ports fade_start  input  1; fade_dir  input  1 (1=fade in, 0=fade out); fade_busy  output  1.

Function
REQ-014 Lookup SHALL be a 2-stage pipeline: rd_idx/rd_valid sampled at edge N yield red/green/blue/out_valid at edge N+2, fully pipelined (one lookup per cycle).
REQ-015 Lookup SHALL read bank active_bank as held at the sampling edge of stage 1.
REQ-016 Write SHALL update entry [wr_bank][wr_idx] at the edge wr_en is sampled high.
REQ-017 Read and write of the same entry at the same edge SHALL return the old value (read-before-write).
REQ-018 bank_req SHALL be latched into a pending register every cycle; active_bank SHALL take the pending value only on the edge where frame_start is high, visible the following cycle.
REQ-019 bank_req changing on the same edge as frame_start SHALL apply the new bank_req value at that frame_start.
REQ-020 bank_req >= NBANKS SHALL be ignored (pending keeps previous value).
REQ-021 out_valid low SHALL leave red/green/blue holding their previous values.
REQ-022 Fade level SHALL be an unsigned value 0..16 (5 bits); each output channel = (entry_ch * level) >> 4, saturated to 2**CH_W-1; level 16 is identity.
REQ-023 Fade FSM states IDLE, FADE_IN, FADE_OUT; fade_start in IDLE enters FADE_IN (fade_dir=1) or FADE_OUT (fade_dir=0).
REQ-024 In FADE_IN level SHALL increment by 1 per frame_start, returning to IDLE on reaching 16; FADE_OUT decrements, returning to IDLE on reaching 0.
REQ-025 fade_start while not IDLE SHALL be ignored; fade_busy SHALL be high exactly when state is not IDLE.
REQ-026 fade_start on the same edge as frame_start SHALL enter the fade state without stepping level that frame.
REQ-027 Fade-in from level 16 or fade-out from level 0 SHALL return to IDLE at the next frame_start with level unchanged.

Reset
REQ-028 Reset_n low SHALL asynchronously set: red/green/blue=0, out_valid=0, pipeline valids=0, active_bank=0, pending bank=0, fade state IDLE, level=16, fade_busy=0.
REQ-029 Reset SHALL load bank 0 entries 0..15 with DEFAULT_PALETTE (channels truncated/zero-extended to CH_W) and all other entries with 0.
REQ-030 Reset asserted mid-fade or mid-lookup SHALL discard in-flight data; first out_valid after release no earlier than edge 2 after first rd_valid.

Configuration
REQ-031 Macro PALETTE_ENGINE_FADE_EN defined: fade FSM and scaling per REQ-022..027 compiled in.
REQ-032 PALETTE_ENGINE_FADE_EN undefined: fade ports remain, fade_start/fade_dir ignored, fade_busy constant 0, outputs unscaled, latency unchanged at 2.

Structure
REQ-033 Package palette_pkg SHALL hold DEFAULT_PALETTE (16 x 12-bit RGB444), the fade state enum and the FADE_FULL=16 constant.
REQ-034 Fade FSM and level counter SHALL be sub-module palette_fade; storage, bank logic and pipeline stay in palette_engine.

Verification
REQ-035 After reset, rd_idx=7 valid -> two edges later {R,G,B}={F,F,F}, out_valid=1; rd_idx=3 -> {2,9,E}.
REQ-036 Write bank1 idx5 = {A,B,C}, bank_req=1, no frame_start -> idx5 still reads bank0 value {6,1,6}; after frame_start pulse -> reads {A,B,C}, active_bank=1.
REQ-037 Same-edge write bank0 idx2={1,2,3} and read idx2 -> returns {D,6,5}; next read -> {1,2,3}.
REQ-038 fade_dir=0, fade_start, 16 frame_starts, read idx7 -> level 0, output {0,0,0}, fade_busy falls after 16th; after 8 frames output {7,7,7}.
REQ-039 Reset_n pulsed low during fade-out and with rd_valid streaming -> out_valid=0, fade_busy=0, level 16, active_bank=0 immediately, bank0 restored to defaults.
